// File: rtl/io.sv
// Req/Ack (4-phase) bridge around a 64-entry RAM FIFO; Ack rises one cycle after an accepted Req.
// Backpressure: a write stalls while full and a read stalls while empty; each Req moves exactly one word.
module io #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ReqW_i,
  input  logic                  ReqR_i,
  input  logic [DATA_WIDTH-1:0] Data_i,
  output logic                  AckW_o,
  output logic                  AckR_o,
  output logic [DATA_WIDTH-1:0] Data_o
);

  typedef enum logic {W_IDLE, W_ACK} w_state_t;
  typedef enum logic {R_IDLE, R_ACK} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;

  // Both flags come from the registered count, so a same-cycle write never
  // bypasses into a read from empty and a same-cycle read never frees a slot.
  assign full  = (count == (ADDR_WIDTH+1)'(RAM_DEPTH));
  assign empty = (count == '0);

  always_comb begin
    w_next = w_state;
    wr_acc = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (ReqW_i && !full) begin
          wr_acc = 1'b1;
          w_next = W_ACK;
        end
      end
      W_ACK: begin
        if (!ReqW_i) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    rd_acc = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (ReqR_i && !empty) begin
          rd_acc = 1'b1;
          r_next = R_ACK;
        end
      end
      R_ACK: begin
        if (!ReqR_i) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Acks are decoded from registered state, so they rise the edge after acceptance.
  assign AckW_o = (w_state == W_ACK);
  assign AckR_o = (r_state == R_ACK);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (reset && wr_acc) mem[wr_ptr] <= Data_i;
  end

  always_ff @(posedge clk) begin
    if (!reset)      Data_o <= '0;
    else if (rd_acc) Data_o <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_io.sv
// Directed + randomized check of the io Req/Ack FIFO bridge against a queue scoreboard.
`timescale 1ns/1ps
module tb_io;

  logic       clk = 1'b0;
  logic       reset;
  logic       ReqW_i, ReqR_i;
  logic [7:0] Data_i;
  logic       AckW_o, AckR_o;
  logic [7:0] Data_o;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  io dut (
    .clk    (clk),
    .reset  (reset),
    .ReqW_i (ReqW_i),
    .ReqR_i (ReqR_i),
    .Data_i (Data_i),
    .AckW_o (AckW_o),
    .AckR_o (AckR_o),
    .Data_o (Data_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Polls at negedges; cyc is the number of edges taken to reach the level.
  task automatic wait_ack(input bit is_w, input logic lvl, input int budget,
                          output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if ((is_w ? AckW_o : AckR_o) === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic write_word(input string tag, input logic [7:0] d, output int lat);
    bit ok;
    int cyc;
    ReqW_i = 1'b1;
    Data_i = d;
    wait_ack(1'b1, 1'b1, 8, lat, ok);
    check({tag, "_ackw"}, ok, 1);
    if (ok) exp_q.push_back(d);
    ReqW_i = 1'b0;
    wait_ack(1'b1, 1'b0, 4, cyc, ok);
    check({tag, "_ackw_drop"}, ok, 1);
  endtask

  task automatic finish_read(input string tag);
    bit ok;
    int cyc;
    wait_ack(1'b0, 1'b1, 8, cyc, ok);
    check({tag, "_ackr"}, ok, 1);
    if (ok) begin
      check({tag, "_q_nonempty"}, exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check({tag, "_data"}, Data_o, exp_q.pop_front());
    end
    ReqR_i = 1'b0;
    wait_ack(1'b0, 1'b0, 4, cyc, ok);
    check({tag, "_ackr_drop"}, ok, 1);
  endtask

  task automatic read_word(input string tag, output int lat);
    bit ok;
    int cyc;
    ReqR_i = 1'b1;
    wait_ack(1'b0, 1'b1, 8, lat, ok);
    check({tag, "_ackr"}, ok, 1);
    if (ok) begin
      check({tag, "_q_nonempty"}, exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check({tag, "_data"}, Data_o, exp_q.pop_front());
    end
    ReqR_i = 1'b0;
    wait_ack(1'b0, 1'b0, 4, cyc, ok);
    check({tag, "_ackr_drop"}, ok, 1);
  endtask

  // A read request held for several cycles must never be acknowledged.
  task automatic expect_empty(input string tag);
    bit seen = 1'b0;
    ReqR_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (AckR_o) seen = 1'b1;
    end
    check(tag, seen, 0);
    ReqR_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int  lat;
    bit  ok, seen;
    int  cyc;
    logic pw, pr;

    reset  = 1'b0;
    ReqW_i = 1'b0;
    ReqR_i = 1'b0;
    Data_i = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ackw", AckW_o, 0);
    check("rst_ackr", AckR_o, 0);
    check("rst_data", Data_o, 0);
    reset = 1'b1;
    @(negedge clk);

    write_word("t2_wr", 8'hA5, lat);
    check("t2_wr_latency", lat, 1);
    read_word("t2_rd", lat);
    check("t2_rd_latency", lat, 1);

    ReqR_i = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (AckR_o) seen = 1'b1;
    end
    check("t3_empty_noack", seen, 0);
    write_word("t3_wr", 8'h3C, lat);
    finish_read("t3_rd");

    for (int i = 0; i < 64; i++) write_word("t4_fill", 8'(i), lat);
    ReqW_i = 1'b1;
    Data_i = 8'hEE;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (AckW_o) seen = 1'b1;
    end
    check("t4_full_stall", seen, 0);
    read_word("t4_first", lat);
    wait_ack(1'b1, 1'b1, 4, cyc, ok);
    check("t4_stalled_ackw", ok, 1);
    if (ok) exp_q.push_back(8'hEE);
    ReqW_i = 1'b0;
    wait_ack(1'b1, 1'b0, 4, cyc, ok);
    check("t4_stalled_drop", ok, 1);
    for (int i = 0; i < 64; i++) read_word("t4_drain", lat);
    expect_empty("t4_empty_after");

    // Data_i keeps changing while Req is held; any rewrite would add extra words.
    ReqW_i = 1'b1;
    Data_i = 8'h77;
    @(negedge clk);
    check("t5_ackw", AckW_o, 1);
    exp_q.push_back(8'h77);
    for (int i = 0; i < 9; i++) begin
      Data_i = 8'(8'h80 + i);
      @(negedge clk);
    end
    check("t5_ackw_held", AckW_o, 1);
    ReqW_i = 1'b0;
    wait_ack(1'b1, 1'b0, 4, cyc, ok);
    check("t5_drop", ok, 1);
    read_word("t5_rd", lat);
    expect_empty("t5_only_one");

    write_word("t6_pre", 8'h11, lat);
    ReqW_i = 1'b1;
    Data_i = 8'h99;
    wait_ack(1'b1, 1'b1, 4, cyc, ok);
    check("t6_ackw_before_rst", ok, 1);
    reset  = 1'b0;
    ReqW_i = 1'b0;
    @(negedge clk);
    check("t6_rst_ackw", AckW_o, 0);
    check("t6_rst_ackr", AckR_o, 0);
    check("t6_rst_data", Data_o, 0);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    expect_empty("t6_count_zero");

    pw = 1'b0;
    pr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (AckW_o && !pw) exp_q.push_back(Data_i);
      if (AckR_o && !pr) begin
        check("rnd_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("rnd_data", Data_o, exp_q.pop_front());
      end
      pw = AckW_o;
      pr = AckR_o;
      if (i % 2 == 0) begin
        if (!ReqW_i && !AckW_o) begin
          if ($urandom_range(1, 0) == 1) begin
            Data_i = 8'($urandom);
            ReqW_i = 1'b1;
          end
        end else if (ReqW_i && AckW_o && $urandom_range(1, 0) == 1) begin
          ReqW_i = 1'b0;
        end
        if (!ReqR_i && !AckR_o) begin
          if ($urandom_range(2, 0) != 0) ReqR_i = 1'b1;
        end else if (ReqR_i && AckR_o && $urandom_range(1, 0) == 1) begin
          ReqR_i = 1'b0;
        end
      end
    end
    ReqW_i = 1'b0;
    ReqR_i = 1'b0;
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) read_word("rnd_drain", lat);
    expect_empty("rnd_final_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
